// File: rtl/fft_twiddle_sequencer_if.sv
// Start-request and twiddle-stream handshake bundle for fft_twiddle_sequencer.
// The sequencer uses the slave modport; the requester/consumer uses the master modport.
interface fft_twiddle_sequencer_if #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned SIZE_FFT  = 32
);
    localparam int unsigned LOG2N   = $clog2(SIZE_FFT);
    localparam int unsigned STAGE_W = $clog2(LOG2N);

    logic                 start_val;
    logic                 start_rdy;
    logic [STAGE_W-1:0]   start_stage;
    logic                 out_val;
    logic                 out_rdy;
    logic [BIT_WIDTH-1:0] out_real;
    logic [BIT_WIDTH-1:0] out_imag;
    logic [LOG2N-1:0]     out_k;
    logic                 out_last;

    modport master (
        output start_val, start_stage, out_rdy,
        input  start_rdy, out_val, out_real, out_imag, out_k, out_last
    );

    modport slave (
        input  start_val, start_stage, out_rdy,
        output start_rdy, out_val, out_real, out_imag, out_k, out_last
    );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Streams the 2^s twiddle factors of one radix-2 FFT stage, taking cos and -sin
// from a single sine table by rotating the table index a quarter and a half turn.
module fft_twiddle_sequencer #(
    parameter int unsigned BIT_WIDTH     = 32,
    parameter int unsigned DECIMAL_POINT = 16,
    parameter int unsigned SIZE_FFT      = 32
) (
    input logic                 clk,
    input logic                 reset,
    input logic [BIT_WIDTH-1:0] sine_wave_in [SIZE_FFT],
    fft_twiddle_sequencer_if.slave bus
);
    localparam int unsigned LOG2N   = $clog2(SIZE_FFT);
    localparam int unsigned STAGE_W = $clog2(LOG2N);

    typedef logic [LOG2N-1:0]   idx_t;
    typedef logic [STAGE_W-1:0] stage_t;
    typedef enum logic {StIdle, StRun} state_e;

    // The format is carried through untouched; only reject nonsensical setups.
    if (DECIMAL_POINT >= BIT_WIDTH || SIZE_FFT < 4) begin : g_param_check
        $error("fft_twiddle_sequencer: bad DECIMAL_POINT or SIZE_FFT");
    end

    state_e               state_q, state_d;
    stage_t               s_q, s_d, s_sel;
    idx_t                 k_q, k_d, k_sel, k_last, j, idx_re, idx_im;
    logic [BIT_WIDTH-1:0] re_q, re_d, im_q, im_d;
    logic                 last_q, last_d;

    // Stage and index whose twiddle gets loaded on the coming start/handshake edge.
    always_comb begin
        s_sel = s_q;
        k_sel = k_q + idx_t'(1);
        if (state_q == StIdle) begin
            k_sel = '0;
            if (32'(bus.start_stage) >= LOG2N) begin
                s_sel = stage_t'(LOG2N - 1);
            end else begin
                s_sel = bus.start_stage;
            end
        end
        k_last = (idx_t'(1) << s_sel) - idx_t'(1);
        j      = k_sel << (stage_t'(LOG2N - 1) - s_sel);
        idx_re = j + idx_t'(SIZE_FFT / 4);
        idx_im = j + idx_t'(SIZE_FFT / 2);
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        re_d    = re_q;
        im_d    = im_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (bus.start_val) begin
                    state_d = StRun;
                    s_d     = s_sel;
                    k_d     = k_sel;
                    re_d    = sine_wave_in[idx_re];
                    im_d    = sine_wave_in[idx_im];
                    last_d  = (k_sel == k_last);
                end
            end
            StRun: begin
                if (bus.out_rdy) begin
                    if (last_q) begin
                        state_d = StIdle;
                        k_d     = '0;
                        re_d    = '0;
                        im_d    = '0;
                        last_d  = 1'b0;
                    end else begin
                        k_d    = k_sel;
                        re_d   = sine_wave_in[idx_re];
                        im_d   = sine_wave_in[idx_im];
                        last_d = (k_sel == k_last);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            k_q     <= '0;
            re_q    <= '0;
            im_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            re_q    <= re_d;
            im_q    <= im_d;
            last_q  <= last_d;
        end
    end

    assign bus.start_rdy = (state_q == StIdle);
    assign bus.out_val   = (state_q == StRun);
    assign bus.out_real  = re_q;
    assign bus.out_imag  = im_q;
    assign bus.out_k     = k_q;
    assign bus.out_last  = last_q;
endmodule
